// File: rtl/res_mem_arb_pkg.sv
// Shared types and encodings for the result-RAM arbiter.
package res_mem_arb_pkg;

    typedef enum logic [1:0] {
        ARB  = 2'b00,
        OWN0 = 2'b01,
        OWN1 = 2'b10
    } arb_state_e;

    localparam int unsigned M_DT   = 0;
    localparam int unsigned M_HOST = 1;

    localparam logic [1:0] OWNER_ARB  = 2'b00;
    localparam logic [1:0] OWNER_OWN0 = 2'b01;
    localparam logic [1:0] OWNER_OWN1 = 2'b10;

    // Status encoding reported on the owner port.
    function automatic logic [1:0] owner_of(arb_state_e s);
        logic [1:0] o;
        o = OWNER_ARB;
        case (s)
            OWN0:    o = OWNER_OWN0;
            OWN1:    o = OWNER_OWN1;
            default: o = OWNER_ARB;
        endcase
        return o;
    endfunction

endpackage

// File: rtl/res_mem_arb_starve.sv
// Saturating count of consecutive cycles the host request is blocked; hit at LIMIT.
module res_mem_arb_starve #(
    parameter int unsigned LIMIT = 8
) (
    input  logic clk,
    input  logic reset,
    input  logic req,
    input  logic gnt,
    output logic hit
);

    localparam int unsigned CW = $clog2(LIMIT + 1);

    logic [CW-1:0] count;

    always_ff @(posedge clk) begin
        if (!reset || !req || gnt) begin
            count <= '0;
        end else if (count != CW'(LIMIT)) begin
            count <= count + CW'(1);
        end
    end

    assign hit = (count == CW'(LIMIT));

endmodule

// File: rtl/res_mem_arbiter.sv
// Single-port result RAM arbiter: DT engine (m0) vs host (m1), with lock and read tag.
// Optional host starvation guard enabled by RES_MEM_ARB_STARVE_GUARD_EN.
module res_mem_arbiter
    import res_mem_arb_pkg::*;
#(
    parameter int unsigned AW           = 14,
    parameter int unsigned DW           = 8,
    parameter int unsigned STARVE_LIMIT = 8
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          m0_req,
    input  logic          m0_wr,
    input  logic          m0_lock,
    input  logic [AW-1:0] m0_addr,
    input  logic [DW-1:0] m0_wdata,
    input  logic          m1_req,
    input  logic          m1_wr,
    input  logic          m1_lock,
    input  logic [AW-1:0] m1_addr,
    input  logic [DW-1:0] m1_wdata,
    output logic          m0_gnt,
    output logic          m1_gnt,
    output logic          m0_rvalid,
    output logic          m1_rvalid,
    output logic [DW-1:0] m0_rdata,
    output logic [DW-1:0] m1_rdata,
    output logic          res_rd,
    output logic          res_wr,
    output logic [AW-1:0] res_addr,
    output logic [DW-1:0] res_do,
    input  logic [DW-1:0] res_di,
    output logic [1:0]    owner
);

    arb_state_e state;
    arb_state_e state_next;
    logic       starve_hit;
    logic       tag_valid;
    logic       tag_master;

`ifdef RES_MEM_ARB_STARVE_GUARD_EN
    res_mem_arb_starve #(
        .LIMIT (STARVE_LIMIT)
    ) u_starve (
        .clk   (clk),
        .reset (reset),
        .req   (m1_req),
        .gnt   (m1_gnt),
        .hit   (starve_hit)
    );
`else
    assign starve_hit = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (!reset) begin
            state <= ARB;
        end else begin
            state <= state_next;
        end
    end

    // Ownership is taken by a locked grant and released on the first unlocked cycle.
    always_comb begin
        state_next = state;
        case (state)
            ARB: begin
                if (m0_gnt && m0_lock) begin
                    state_next = OWN0;
                end else if (m1_gnt && m1_lock) begin
                    state_next = OWN1;
                end
            end
            OWN0:    if (!m0_lock) state_next = ARB;
            OWN1:    if (!m1_lock) state_next = ARB;
            default: state_next = ARB;
        endcase
    end

    // Grants are combinational and forced low throughout reset.
    always_comb begin
        m0_gnt = 1'b0;
        m1_gnt = 1'b0;
        if (reset) begin
            case (state)
                ARB: begin
                    if (starve_hit && m1_req) begin
                        m1_gnt = 1'b1;
                    end else begin
                        m0_gnt = m0_req;
                        m1_gnt = m1_req & ~m0_req;
                    end
                end
                OWN0:    m0_gnt = m0_req;
                OWN1:    m1_gnt = m1_req;
                default: ;
            endcase
        end
    end

    always_comb begin
        res_rd   = (m0_gnt & ~m0_wr) | (m1_gnt & ~m1_wr);
        res_wr   = (m0_gnt & m0_wr) | (m1_gnt & m1_wr);
        res_addr = '0;
        res_do   = '0;
        if (m0_gnt) begin
            res_addr = m0_addr;
            res_do   = m0_wdata;
        end else if (m1_gnt) begin
            res_addr = m1_addr;
            res_do   = m1_wdata;
        end
    end

    // Read tag: remembers which master owns the data returning next cycle.
    always_ff @(posedge clk) begin
        if (!reset) begin
            tag_valid  <= 1'b0;
            tag_master <= 1'(M_DT);
        end else begin
            tag_valid  <= res_rd;
            tag_master <= m1_gnt ? 1'(M_HOST) : 1'(M_DT);
        end
    end

    assign m0_rvalid = reset & tag_valid & (tag_master == 1'(M_DT));
    assign m1_rvalid = reset & tag_valid & (tag_master == 1'(M_HOST));
    assign m0_rdata  = res_di;
    assign m1_rdata  = res_di;
    assign owner     = owner_of(state);

endmodule
